// File: rtl/apb_wakeup_timer_pkg.sv
// Shared event-unit definitions: wake-up timer register map and CTRL/STATUS bit positions.
// Latency: n/a (constants and pure helper functions).
// Backpressure: n/a.
package apb_wakeup_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_CMP    = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_PERIODIC_BIT = 1;
    localparam int CTRL_EVT_EN_BIT   = 2;
    localparam int CTRL_IRQ_EN_BIT   = 3;

    localparam int STATUS_MATCH_BIT  = 0;

    typedef struct packed {
        logic irq_en;
        logic evt_en;
        logic periodic;
        logic en;
    } ctrl_t;

    function automatic ctrl_t ctrl_from_bits(input logic [3:0] w);
        ctrl_t c;
        c.en       = w[CTRL_EN_BIT];
        c.periodic = w[CTRL_PERIODIC_BIT];
        c.evt_en   = w[CTRL_EVT_EN_BIT];
        c.irq_en   = w[CTRL_IRQ_EN_BIT];
        return c;
    endfunction

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w                    = '0;
        w[CTRL_EN_BIT]       = c.en;
        w[CTRL_PERIODIC_BIT] = c.periodic;
        w[CTRL_EVT_EN_BIT]   = c.evt_en;
        w[CTRL_IRQ_EN_BIT]   = c.irq_en;
        return w;
    endfunction

endpackage

// File: rtl/ls_clk_edge_sync.sv
// Brings the 32 kHz reference into HCLK and emits one tick per rising edge (or every cycle in bypass).
// Latency: edge sampled at the end of cycle k gives tick in cycle k+2.
// Backpressure: none; free-running.
module ls_clk_edge_sync (
    input  logic HCLK,
    input  logic HRESET,
    input  logic clk32_i,
    input  logic clk32_en_i,
    output logic tick
);

    logic [2:0] sync_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], clk32_i};
        end
    end

    // sync_q[0] may be metastable; the edge is taken from the two settled stages
    assign tick = ~clk32_en_i | (sync_q[1] & ~sync_q[2]);

endmodule

// File: rtl/apb_wakeup_timer.sv
// APB wake-up timer: counts low-speed ticks, pulses event_o and flags a level irq on compare match.
// Latency: match tick -> event_o/irq_o next HCLK; APB read data combinational in the access phase.
// Backpressure: none; PREADY tied high, no wait states.
module apb_wakeup_timer
    import apb_wakeup_timer_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic                      clk32_i,
    input  logic                      clk32_en_i,
    output logic                      event_o,
    output logic                      irq_o
);

    logic                 tick;
    logic [1:0]           reg_idx;
    logic                 wr_access;
    logic                 rd_access;
    logic                 wr_ctrl;
    logic                 wr_cmp;
    logic                 wr_count;
    logic                 wr_status;
    logic                 cnt_go;
    logic                 hit;
    logic                 unused_bits;

    ctrl_t                ctrl_q;
    ctrl_t                ctrl_d;
    logic [CNT_WIDTH-1:0] cmp_q;
    logic [CNT_WIDTH-1:0] cmp_d;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic                 match_q;
    logic                 match_d;
    logic                 event_q;
    logic                 irq_q;

    ls_clk_edge_sync u_edge_sync (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .clk32_i    (clk32_i),
        .clk32_en_i (clk32_en_i),
        .tick       (tick)
    );

    assign reg_idx   = PADDR[3:2];
    assign wr_access = PSEL & PENABLE & PWRITE;
    assign rd_access = PSEL & PENABLE & ~PWRITE;
    assign wr_ctrl   = wr_access & (reg_idx == REG_CTRL);
    assign wr_cmp    = wr_access & (reg_idx == REG_CMP);
    assign wr_count  = wr_access & (reg_idx == REG_COUNT);
    assign wr_status = wr_access & (reg_idx == REG_STATUS);

    // A software COUNT write owns the counter for that cycle: no increment, no match
    assign cnt_go = ctrl_q.en & tick & ~wr_count;
    assign hit    = cnt_go & (count_q == cmp_q);

    always_comb begin
        ctrl_d  = ctrl_q;
        cmp_d   = cmp_q;
        count_d = count_q;
        match_d = match_q;

        if (cnt_go) begin
            count_d = hit ? '0 : count_q + CNT_WIDTH'(1);
        end
        if (hit && !ctrl_q.periodic) begin
            ctrl_d.en = 1'b0;
        end

        if (wr_ctrl) begin
            ctrl_d = ctrl_from_bits(PWDATA[3:0]);
        end
        if (wr_cmp) begin
            cmp_d = PWDATA[CNT_WIDTH-1:0];
        end
        if (wr_count) begin
            count_d = PWDATA[CNT_WIDTH-1:0];
        end
        if (wr_status && PWDATA[STATUS_MATCH_BIT]) begin
            match_d = 1'b0;
        end
        // hardware set beats a simultaneous write-1-to-clear
        if (hit) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl_q  <= '0;
            cmp_q   <= '0;
            count_q <= '0;
            match_q <= 1'b0;
            event_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            cmp_q   <= cmp_d;
            count_q <= count_d;
            match_q <= match_d;
            event_q <= hit & ctrl_q.evt_en;
            irq_q   <= match_d & ctrl_d.irq_en;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (rd_access) begin
            case (reg_idx)
                REG_CTRL:   PRDATA = ctrl_to_word(ctrl_q);
                REG_CMP:    PRDATA[CNT_WIDTH-1:0] = cmp_q;
                REG_COUNT:  PRDATA[CNT_WIDTH-1:0] = count_q;
                REG_STATUS: PRDATA[STATUS_MATCH_BIT] = match_q;
                default:    PRDATA = '0;
            endcase
        end
    end

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign event_o     = event_q;
    assign irq_o       = irq_q;
    assign unused_bits = ^{PADDR, PWDATA};

endmodule

// File: tb/tb_apb_wakeup_timer.sv
// Self-checking bench for apb_wakeup_timer: register table, directed corner sequences, randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_apb_wakeup_timer;

    localparam int AW = 12;
    localparam int CW = 32;
    localparam longint unsigned MASK = (64'd1 << CW) - 64'd1;

    logic          HCLK       = 1'b0;
    logic          HRESET     = 1'b1;
    logic [AW-1:0] PADDR      = '0;
    logic [31:0]   PWDATA     = '0;
    logic          PWRITE     = 1'b0;
    logic          PSEL       = 1'b0;
    logic          PENABLE    = 1'b0;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic          clk32_i    = 1'b0;
    logic          clk32_en_i = 1'b0;
    logic          event_o;
    logic          irq_o;

    apb_wakeup_timer #(
        .APB_ADDR_WIDTH (AW),
        .CNT_WIDTH      (CW)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .clk32_i    (clk32_i),
        .clk32_en_i (clk32_en_i),
        .event_o    (event_o),
        .irq_o      (irq_o)
    );

    always #5 HCLK = ~HCLK;

    // reference model state
    bit              m_en, m_per, m_evt, m_irqen, m_match;
    longint unsigned m_cmp, m_count;
    bit              samples[$];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          idx;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_read(input int idx);
        case (idx)
            0:       return 64'({m_irqen, m_evt, m_per, m_en});
            1:       return 64'(m_cmp);
            2:       return 64'(m_count);
            default: return 64'(m_match);
        endcase
    endfunction

    // Advance one HCLK: predict the effect of the current inputs, clock, then compare outputs.
    task automatic step();
        bit   tick, wr, cnt_go, hit;
        int   idx;
        logic exp_evt;
        idx     = int'(PADDR[3:2]);
        wr      = PSEL && PENABLE && PWRITE;
        exp_evt = 1'b0;
        if (HRESET) begin
            {m_en, m_per, m_evt, m_irqen, m_match} = '0;
            m_cmp   = 0;
            m_count = 0;
            samples = '{1'b0, 1'b0, 1'b0};
        end else begin
            // tick = a rising edge of clk32 seen two samples back, or every cycle in bypass
            tick    = !clk32_en_i || (samples[1] && !samples[0]);
            cnt_go  = m_en && tick && !(wr && idx == 2);
            hit     = cnt_go && (m_count == m_cmp);
            exp_evt = hit && m_evt;
            if (cnt_go) m_count = hit ? 64'd0 : ((m_count + 64'd1) & MASK);
            if (hit && !m_per) m_en = 1'b0;
            if (wr) begin
                case (idx)
                    0:       {m_irqen, m_evt, m_per, m_en} = PWDATA[3:0];
                    1:       m_cmp = 64'(PWDATA) & MASK;
                    2:       m_count = 64'(PWDATA) & MASK;
                    default: if (PWDATA[0]) m_match = 1'b0;
                endcase
            end
            if (hit) m_match = 1'b1;
            samples.push_back(clk32_i);
            void'(samples.pop_front());
        end
        @(posedge HCLK);
        #1;
        check("event_o", 64'(event_o), 64'(exp_evt));
        check("irq_o", 64'(irq_o), 64'(m_match && m_irqen));
        check("pready", 64'(PREADY), 64'd1);
        check("pslverr", 64'(PSLVERR), 64'd0);
        if (!(PSEL && PENABLE && !PWRITE)) check("prdata_idle", 64'(PRDATA), 64'd0);
    endtask

    task automatic apb_write(input int idx, input logic [31:0] data);
        PADDR      = AW'($urandom);
        PADDR[3:2] = idx[1:0];
        PWDATA     = data;
        PWRITE     = 1'b1;
        PSEL       = 1'b1;
        PENABLE    = 1'b0;
        step();
        PENABLE = 1'b1;
        step();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input int idx, input string name, output logic [31:0] data);
        PADDR      = AW'($urandom);
        PADDR[3:2] = idx[1:0];
        PWDATA     = $urandom;
        PWRITE     = 1'b0;
        PSEL       = 1'b1;
        PENABLE    = 1'b0;
        step();
        PENABLE = 1'b1;
        #1;
        check(name, 64'(PRDATA), model_read(idx));
        data = PRDATA;
        step();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic do_reset();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        HRESET  = 1'b1;
        step();
        step();
        HRESET = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        logic [31:0] rd;
        int          nevt, first, at;

        samples = '{1'b0, 1'b0, 1'b0};
        tbl[0] = '{0, 32'hFFFF_FFF6, 32'h0000_0006};
        tbl[1] = '{1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[2] = '{2, 32'h1234_5678, 32'h1234_5678};
        tbl[3] = '{3, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[4] = '{0, 32'h0000_000A, 32'h0000_000A};
        tbl[5] = '{2, 32'h0000_0000, 32'h0000_0000};

        // reset state
        do_reset();
        check("rst_event", 64'(event_o), 64'd0);
        check("rst_irq", 64'(irq_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            apb_read(i, "rst_read", rd);
            check($sformatf("rst_reg%0d", i), 64'(rd), 64'd0);
        end

        // register table, EN kept off
        for (int i = 0; i < 6; i++) begin
            apb_write(tbl[i].idx, tbl[i].wdata);
            apb_read(tbl[i].idx, "tbl_read", rd);
            check($sformatf("tbl%0d", i), 64'(rd), 64'(tbl[i].rexp));
        end

        // one-shot, fast tick
        do_reset();
        apb_write(1, 32'd3);
        apb_write(0, 32'h5);
        nevt = 0; first = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (event_o) begin
                nevt++;
                if (first < 0) first = i;
            end
        end
        check("oneshot_delay", 64'(first), 64'd4);
        check("oneshot_events", 64'(nevt), 64'd1);
        apb_read(0, "oneshot_ctrl_rd", rd);
        check("oneshot_ctrl", 64'(rd), 64'h4);
        apb_read(2, "oneshot_count_rd", rd);
        check("oneshot_count", 64'(rd), 64'h0);
        apb_read(3, "oneshot_status_rd", rd);
        check("oneshot_status", 64'(rd), 64'h1);

        // periodic + irq + W1C
        do_reset();
        apb_write(1, 32'd1);
        apb_write(0, 32'hF);
        nevt = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (event_o) nevt++;
        end
        check("periodic_events", 64'(nevt), 64'd5);
        check("periodic_irq", 64'(irq_o), 64'd1);
        step();
        apb_write(3, 32'd1);
        check("w1c_irq_drop", 64'(irq_o), 64'd0);
        step();
        check("irq_reassert", 64'(irq_o), 64'd1);
        apb_write(3, 32'd1);
        apb_read(3, "w1c_collide_rd", rd);
        check("w1c_collide", 64'(rd), 64'd1);

        // synchronized clk32 edges
        do_reset();
        clk32_en_i = 1'b1;
        clk32_i    = 1'b0;
        apb_write(1, 32'd2);
        apb_write(0, 32'h5);
        nevt = 0; at = -1;
        for (int r = 1; r <= 3; r++) begin
            clk32_i = 1'b1;
            for (int i = 1; i <= 8; i++) begin
                step();
                if (event_o) begin
                    nevt++;
                    if (r == 3) at = i;
                end
            end
            clk32_i = 1'b0;
            for (int i = 1; i <= 8; i++) begin
                step();
                if (event_o) nevt++;
            end
        end
        check("sync_delay", 64'(at), 64'd3);
        check("sync_events", 64'(nevt), 64'd1);
        apb_read(0, "sync_ctrl", rd);
        check("sync_ctrl_oneshot", 64'(rd), 64'h4);

        // COUNT write on a tick that would also have matched
        do_reset();
        clk32_en_i = 1'b1;
        clk32_i    = 1'b0;
        apb_write(2, 32'd5);
        apb_write(1, 32'd5);
        apb_write(0, 32'h1);
        clk32_i = 1'b1;
        step();
        apb_write(2, 32'h10);
        apb_read(2, "cnt_collide_rd", rd);
        check("cnt_collide_count", 64'(rd), 64'h10);
        apb_read(3, "cnt_collide_st_rd", rd);
        check("cnt_collide_status", 64'(rd), 64'h0);
        apb_read(0, "cnt_collide_ctrl_rd", rd);
        check("cnt_collide_ctrl", 64'(rd), 64'h1);

        // wrap from all-ones without a flag
        do_reset();
        clk32_en_i = 1'b0;
        apb_write(1, 32'd5);
        apb_write(2, 32'hFFFF_FFFF);
        apb_write(0, 32'h1);
        apb_write(0, 32'h0);
        apb_read(2, "wrap_rd", rd);
        check("wrap_count", 64'(rd), 64'd1);
        apb_read(3, "wrap_st_rd", rd);
        check("wrap_status", 64'(rd), 64'd0);

        // reset mid-count
        do_reset();
        apb_write(1, 32'd100);
        apb_write(0, 32'h5);
        for (int i = 0; i < 48; i++) step();
        apb_read(2, "mid_rd", rd);
        check("mid_count", 64'(rd), 64'd49);
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        check("mid_rst_event", 64'(event_o), 64'd0);
        apb_read(2, "mid_rst_count_rd", rd);
        check("mid_rst_count", 64'(rd), 64'd0);
        apb_read(0, "mid_rst_ctrl_rd", rd);
        check("mid_rst_ctrl", 64'(rd), 64'd0);
        nevt = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (event_o) nevt++;
        end
        check("mid_rst_no_event", 64'(nevt), 64'd0);

        // randomized traffic against the model
        do_reset();
        for (int it = 0; it < 600; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 7) == 0) clk32_en_i = ~clk32_en_i;
            if ($urandom_range(0, 2) == 0) clk32_i = ~clk32_i;
            if (r < 3) begin
                do_reset();
            end else if (r < 25) begin
                apb_write(0, $urandom | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0));
            end else if (r < 38) begin
                apb_write(1, 32'($urandom_range(0, 6)));
            end else if (r < 48) begin
                if ($urandom_range(0, 3) == 0) apb_write(2, 32'hFFFF_FFFC + 32'($urandom_range(0, 3)));
                else apb_write(2, 32'($urandom_range(0, 6)));
            end else if (r < 58) begin
                apb_write(3, $urandom);
            end else if (r < 78) begin
                apb_read($urandom_range(0, 3), "rand_read", rd);
            end else begin
                for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
                    if ($urandom_range(0, 2) == 0) clk32_i = ~clk32_i;
                    step();
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_wakeup_timer.md
Name: apb_wakeup_timer

Overview:
- APB-programmable wake-up timer clocked on HCLK. It counts rising edges of the 32 kHz low-speed reference clock.
- On compare match it raises a single-cycle event pulse and an optional level interrupt.
- It sits directly upstream of the sleep controller: event_o drives that block's event_i, so the core can leave SLEEP/EXT_SLEEP after a programmed delay.
- It stays powered and clocked while the core is gated.

Parameters:
APB_ADDR_WIDTH  12  APB address width (4 KB slave window)
CNT_WIDTH  32  counter and compare width, 1..32; register reads zero-extend to 32 bits

Ports:
HCLK  in  1  system clock; the only clock
HRESET  in  1  reset, synchronous, active-high
PADDR  in  APB_ADDR_WIDTH  APB address; PADDR[3:2] selects the register
PWDATA  in  32  APB write data
PWRITE  in  1  APB write
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PRDATA  out  32  APB read data
PREADY  out  1  tied 1
PSLVERR  out  1  tied 0
clk32_i  in  1  32 kHz reference, asynchronous to HCLK
clk32_en_i  in  1  0 = tick every HCLK cycle (fast/sim mode)
event_o  out  1  one-HCLK wake pulse, to sleep controller event_i
irq_o  out  1  level interrupt

Behaviour:
- Single clock, HRESET synchronous active-high; all flops update on posedge HCLK.
- Reset values: all registers 0, sync flops 0, event_o=0, irq_o=0.
- Register map (word index = PADDR[3:2]):
  - 0 CTRL rw: bit0 EN, bit1 PERIODIC, bit2 EVT_EN, bit3 IRQ_EN; other bits read 0.
  - 1 CMP rw.
  - 2 COUNT rw.
  - 3 STATUS: bit0 MATCH, write-1-to-clear.
- APB write qualifies on PSEL&PENABLE&PWRITE. There are no wait states.
- APB read: PRDATA is combinational when PSEL&PENABLE&!PWRITE, otherwise 0.
- Tick generation: 3-flop shift register samples clk32_i. tick = ~clk32_en_i | (sync[1] & ~sync[2]), so there is at most one tick per clk32 rising edge.
- Counting, when EN=1 and tick=1:
  - If COUNT==CMP: match fires.
  - Otherwise COUNT <= COUNT+1, wrapping from all-ones to 0 with no flag.
- When EN=0, COUNT holds. Setting EN does not clear COUNT.
- On match:
  - COUNT <= 0 and STATUS.MATCH <= 1.
  - If PERIODIC=0, EN <= 0 (one-shot).
  - Period is therefore CMP+1 ticks. CMP=0 matches on every tick.
- event_o is registered: 1 for exactly one HCLK, the cycle after a match tick, and only if EVT_EN=1. It is never stretched.
- irq_o is registered: equals STATUS.MATCH & IRQ_EN.
- Collisions:
  - APB write to COUNT in the same cycle as a tick: APB value wins; no increment and no match that cycle.
  - APB write to CTRL in the same cycle as a one-shot match: the APB write wins.
  - Hardware set of MATCH in the same cycle as a W1C clear: set wins.
- Writing CMP below the current COUNT: the counter runs to wrap before matching. This is intended.
- HRESET asserted mid-count: next cycle all state is 0 and no event_o is emitted.
- Latency, clk32_en_i=1: a clk32_i rise sampled in cycle k gives tick in cycle k+2 and event_o in cycle k+3.

Decomposition:
- Register word indices, CTRL bit positions and STATUS bit position go in the shared event-unit defines include, alongside the sleep-controller defines.
- One sub-module: ls_clk_edge_sync. It holds the 3-flop synchronizer, the rising-edge detect and the clk32_en_i bypass. The sleep controller can reuse it.

Test Plan:
- Reset check: after HRESET, all four registers read 0 and event_o=irq_o=0. PREADY=1 and PSLVERR=0 at all times.
- One-shot, clk32_en_i=0: CMP=3, CTRL=0x5 -> event_o high exactly once, 4 cycles after the write completes; then CTRL=0x4, COUNT=0, STATUS=1.
- Periodic, clk32_en_i=0: CMP=1, CTRL=0xF -> event_o pulses every 2 cycles; irq_o stays 1. Write STATUS=1 -> irq_o drops, then reasserts at the next match.
- Synchronized edges, clk32_en_i=1: clk32_i toggles every 8 HCLK, CMP=2, one-shot -> event_o fires 3 cycles after the 3rd clk32_i rising edge sample. No double count per edge.
- Collisions: W1C STATUS on a match cycle -> MATCH reads 1. COUNT write of 0x10 on a tick cycle -> COUNT reads 0x10 with no match.
- Reset mid-count: CMP=100, COUNT reaches 50, HRESET pulsed for 1 cycle -> COUNT=0, EN=0, no event_o thereafter.
